// File: rtl/fetch_unit_if.sv
// Instruction-memory handshake between the fetch stage and instruction memory.
// The fetch stage drives the request and address; memory answers with one
// ack (plus data) per request, possibly in the same cycle as the request.
interface fetch_unit_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;

    modport master (
        output im_req,
        output im_addr,
        input  im_ack,
        input  im_rdata
    );

    modport slave (
        input  im_req,
        input  im_addr,
        output im_ack,
        output im_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the P5 pipeline.
// Owns the PC, requests instructions over a variable-latency handshake and
// writes the IF/ID register (nI/nPC/WE). Branch/jump redirects follow MIPS
// delay-slot rules: the instruction delivered while a redirect is live is
// the delay slot; its successor comes from the target. A slow memory with no
// stall produces a nop bubble; if a redirect leaves ID on a bubble it is
// remembered in redir_pend and applied when the delay slot is delivered.
// Optional feature: define PERF_CNT_EN to add bubble_cnt/hold_cnt counters.
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  PCSrc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic [31:0] j_target,
    input  logic [31:0] jr_target,
    input  logic        stall,
    fetch_unit_if.master im,
    output logic [31:0] nI,
    output logic [31:0] nPC,
    output logic        WE
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] bubble_cnt,
    output logic [31:0] hold_cnt
`endif
);

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [0:0]  state;
    logic [31:0] pc;
    logic [31:0] hold_buf;
    logic        redir_pend;
    logic [31:0] redir_tgt;

    logic        redirect_live;
    logic [31:0] live_tgt;
    logic [31:0] next_pc;
    logic        advance;
    logic        capture;
    logic        bubble;

    // Decode the redirect requested by the instruction in ID and pick the next PC.
    always_comb begin
        redirect_live = ((PCSrc == 2'd1) && br_taken) || (PCSrc == 2'd2) || (PCSrc == 2'd3);
        case (PCSrc)
            2'd1:    live_tgt = br_target;
            2'd2:    live_tgt = j_target;
            2'd3:    live_tgt = jr_target;
            default: live_tgt = br_target;
        endcase
        if (redirect_live) begin
            next_pc = live_tgt;
        end else if (redir_pend) begin
            next_pc = redir_tgt;
        end else begin
            next_pc = pc + 32'd4;
        end
    end

    // Handshake and IF/ID write decisions; everything is held quiet while in reset.
    always_comb begin
        im.im_req = 1'b0;
        WE        = 1'b0;
        nI        = 32'h0;
        advance   = 1'b0;
        capture   = 1'b0;
        bubble    = 1'b0;
        if (reset) begin
            if (state == ST_FETCH) begin
                im.im_req = 1'b1;
                if (im.im_ack && !stall) begin
                    WE      = 1'b1;
                    nI      = im.im_rdata;
                    advance = 1'b1;
                end else if (im.im_ack) begin
                    capture = 1'b1;
                end else if (!stall) begin
                    WE     = 1'b1;
                    bubble = 1'b1;
                end
            end else if (!stall) begin
                WE      = 1'b1;
                nI      = hold_buf;
                advance = 1'b1;
            end
        end
    end

    assign im.im_addr = pc;
    assign nPC        = pc;

    // PC, FSM, stall buffer and pending-redirect state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= PC_RESET;
            state      <= ST_FETCH;
            hold_buf   <= 32'h0;
            redir_pend <= 1'b0;
            redir_tgt  <= 32'h0;
        end else begin
            if (advance) begin
                pc <= next_pc;
                if (!redirect_live) begin
                    redir_pend <= 1'b0;
                end
            end
            if (bubble && redirect_live) begin
                redir_pend <= 1'b1;
                redir_tgt  <= live_tgt;
            end
            if (capture) begin
                hold_buf <= im.im_rdata;
                state    <= ST_HOLD;
            end
            if ((state == ST_HOLD) && !stall) begin
                state <= ST_FETCH;
            end
        end
    end

`ifdef PERF_CNT_EN
    // Count bubble cycles and cycles spent holding a stalled instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt <= 32'h0;
            hold_cnt   <= 32'h0;
        end else begin
            if (bubble) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
            if (state == ST_HOLD) begin
                hold_cnt <= hold_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
